// File: rtl/shift64_seq_pkg.sv
// Shared types for the 64-bit double-word shift sequencer: state encoding,
// control-bit positions and the latched-operation record.
package shift64_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_P_HI = 3'd1,
      S_P_LO = 3'd2,
      S_P_X  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Bit positions inside the direction/arith control field (shared with the decoder)
   localparam int CTL_RIGHT = 0;
   localparam int CTL_ARITH = 1;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic [5:0]  sa;
      logic [1:0]  ctl;
   } op_t;

   // Complementary shift distance for the cross-word phase, (32-k) mod 32
   function automatic logic [4:0] neg5(input logic [4:0] k);
      return 5'd0 - k;
   endfunction

endpackage

// File: rtl/shift64_seq_shifter.sv
// 32-bit combinational shifter shared by every phase of the sequencer.
module SHIFTER_32 (
   input  logic [31:0] a,
   input  logic [4:0]  k,
   input  logic        right,
   input  logic        Arith,
   output logic [31:0] y
);

   logic signed [31:0] a_s;

   always_comb begin
      a_s = a;
      if (!right)     y = a << k;
      else if (Arith) y = a_s >>> k;
      else            y = a >> k;
   end

endmodule

// File: rtl/shift64_seq.sv
// Multi-cycle 64-bit shifter: builds {hi,lo} shifts from up to three passes
// through one 32-bit shifter, with a start/busy/done handshake.
module shift64_seq
   import shift64_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] hi_in,
   input  logic [31:0] lo_in,
   input  logic [5:0]  sa,
   input  logic        arith,
   input  logic        right,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   state_t      state;
   op_t         op;
   logic [31:0] acc_hi, acc_lo;

   logic [4:0]  k, kc;
   logic        big, r, ar;
   logic [31:0] sh_a, sh_y;
   logic [4:0]  sh_k;
   logic        sh_r, sh_ar;

   assign k   = op.sa[4:0];
   assign kc  = neg5(k);
   assign big = op.sa[5];
   assign r   = op.ctl[CTL_RIGHT];
   assign ar  = op.ctl[CTL_ARITH] & r;

   // Shifter input muxes; only a right shift of the high word may sign-fill
   always_comb begin
      sh_a  = op.lo;
      sh_k  = k;
      sh_r  = 1'b0;
      sh_ar = 1'b0;
      case (state)
         S_P_HI: begin
            if (big && !r) begin
               sh_a = op.lo;
            end else begin
               sh_a  = op.hi;
               sh_r  = r;
               sh_ar = ar;
            end
         end
         S_P_LO: begin
            sh_a = op.lo;
            sh_r = r;
         end
         S_P_X: begin
            sh_k = kc;
            sh_a = r ? op.hi : op.lo;
            sh_r = ~r;
         end
         default: ;
      endcase
   end

   SHIFTER_32 u_shifter (
      .a     (sh_a),
      .k     (sh_k),
      .right (sh_r),
      .Arith (sh_ar),
      .y     (sh_y)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         op     <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         hi_out <= '0;
         lo_out <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  op   <= '{hi: hi_in, lo: lo_in, sa: sa, ctl: {arith, right}};
                  busy <= 1'b1;
                  if (sa == 6'd0) begin
                     hi_out <= hi_in;
                     lo_out <= lo_in;
                     done   <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     state <= S_P_HI;
                  end
               end
            end
            S_P_HI: begin
               if (big) begin
                  if (r) begin
                     acc_hi <= {32{ar & op.hi[31]}};
                     acc_lo <= sh_y;
                     hi_out <= {32{ar & op.hi[31]}};
                     lo_out <= sh_y;
                  end else begin
                     acc_hi <= sh_y;
                     acc_lo <= '0;
                     hi_out <= sh_y;
                     lo_out <= '0;
                  end
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  acc_hi <= sh_y;
                  state  <= S_P_LO;
               end
            end
            S_P_LO: begin
               acc_lo <= sh_y;
               state  <= S_P_X;
            end
            S_P_X: begin
               if (r) begin
                  acc_lo <= acc_lo | sh_y;
                  lo_out <= acc_lo | sh_y;
                  hi_out <= acc_hi;
               end else begin
                  acc_hi <= acc_hi | sh_y;
                  hi_out <= acc_hi | sh_y;
                  lo_out <= acc_lo;
               end
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shift64_seq.sv
// Self-checking bench for shift64_seq: directed table, random ops against a
// 64-bit arithmetic model, start-while-busy and reset-mid-operation sequences.
module tb_shift64_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] hi_in, lo_in;
   logic [5:0]  sa;
   logic        arith, right;
   logic        busy, done;
   logic [31:0] hi_out, lo_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   shift64_seq dut (
      .clk(clk), .rst(rst), .start(start), .hi_in(hi_in), .lo_in(lo_in),
      .sa(sa), .arith(arith), .right(right), .busy(busy), .done(done),
      .hi_out(hi_out), .lo_out(lo_out)
   );

   typedef struct {
      logic [31:0] hi, lo;
      logic [5:0]  sa;
      logic        ar, r;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] h, input logic [31:0] l,
                                         input logic [5:0] s, input logic a, input logic rr);
      logic [63:0]        x;
      logic signed [63:0] xs;
      x  = {h, l};
      xs = x;
      if (!rr)   return x << s;
      else if (a) return xs >>> s;
      else        return x >> s;
   endfunction

   function automatic int model_lat(input logic [5:0] s);
      if (s == 0)  return 1;
      if (s >= 32) return 2;
      return 4;
   endfunction

   task automatic issue(input logic [31:0] h, input logic [31:0] l, input logic [5:0] s,
                        input logic a, input logic rr);
      @(negedge clk);
      hi_in = h; lo_in = l; sa = s; arith = a; right = rr; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hi_in = ~h; lo_in = ~l; sa = ~s;
   endtask

   // Issue one op, then count cycles until done; busy must hold until done.
   task automatic run_op(input string name, input logic [31:0] h, input logic [31:0] l,
                         input logic [5:0] s, input logic a, input logic rr,
                         input logic [63:0] exp, input int lat);
      int  cyc;
      logic busy_ok;
      busy_ok = 1'b1;
      issue(h, l, s, a, rr);
      cyc = 1;
      while (!done && cyc < 10) begin
         if (!busy) busy_ok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      chk({name, " latency"}, 64'(cyc), 64'(lat));
      chk({name, " result"}, {hi_out, lo_out}, exp);
      chk({name, " busy"}, {63'd0, busy & busy_ok}, 64'd1);
      @(negedge clk);
      chk({name, " idle"}, {62'd0, busy, done}, 64'd0);
   endtask

   initial begin
      logic [31:0] h, l;
      logic [5:0]  s;
      logic        a, rr;
      int          extra;

      vecs[0] = '{32'h12345678, 32'h9ABCDEF0, 6'd4,  1'b0, 1'b0, 64'h23456789_ABCDEF00, 4};
      vecs[1] = '{32'h80000000, 32'h00000000, 6'd36, 1'b0, 1'b1, 64'h00000000_08000000, 2};
      vecs[2] = '{32'h80000000, 32'h00000000, 6'd36, 1'b1, 1'b1, 64'hFFFFFFFF_F8000000, 2};
      vecs[3] = '{32'h80000000, 32'h00000001, 6'd1,  1'b1, 1'b1, 64'hC0000000_00000000, 4};
      vecs[4] = '{32'h00000000, 32'h00000001, 6'd63, 1'b0, 1'b0, 64'h80000000_00000000, 2};
      vecs[5] = '{32'hDEADBEEF, 32'h12345678, 6'd0,  1'b0, 1'b0, 64'hDEADBEEF_12345678, 1};

      rst = 1'b1; start = 1'b0; hi_in = '0; lo_in = '0; sa = '0; arith = 1'b0; right = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset state", {hi_out, lo_out}, 64'd0);
      chk("reset flags", {62'd0, busy, done}, 64'd0);
      rst = 1'b0;

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo, vecs[i].sa, vecs[i].ar,
                vecs[i].r, vecs[i].exp, vecs[i].lat);

      for (int i = 0; i < 40; i++) begin
         h = $urandom; l = $urandom; s = 6'($urandom_range(0, 63));
         a = 1'($urandom); rr = 1'($urandom);
         if (i < 4) s = (i == 0) ? 6'd31 : (i == 1) ? 6'd32 : (i == 2) ? 6'd0 : 6'd63;
         run_op($sformatf("rand%0d sa=%0d a=%0d r=%0d", i, s, a, rr), h, l, s, a, rr,
                model(h, l, s, a, rr), model_lat(s));
      end

      // Second start during P_LO with different operands must be ignored
      issue(32'h12345678, 32'h9ABCDEF0, 6'd4, 1'b0, 1'b0);   // now in P_HI
      @(negedge clk);                                          // now in P_LO
      hi_in = 32'hFFFF0000; lo_in = 32'h0000FFFF; sa = 6'd40; right = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      extra = 0;
      while (!done && extra < 10) begin @(negedge clk); extra++; end
      chk("busy-start latency", 64'(extra), 64'd1);
      chk("busy-start result", {hi_out, lo_out}, 64'h23456789_ABCDEF00);
      extra = 0;
      for (int i = 0; i < 6; i++) begin @(negedge clk); if (done) extra++; end
      chk("busy-start no second done", 64'(extra), 64'd0);

      // Reset while in P_X
      issue(32'h0F0F0F0F, 32'hF0F0F0F0, 6'd4, 1'b0, 1'b0);   // P_HI
      @(negedge clk);                                          // P_LO
      @(negedge clk);                                          // P_X
      rst = 1'b1;
      #2;
      chk("mid-reset outputs", {hi_out, lo_out}, 64'd0);
      chk("mid-reset flags", {62'd0, busy, done}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      extra = 0;
      for (int i = 0; i < 5; i++) begin @(negedge clk); if (done || busy) extra++; end
      chk("post-reset quiet", 64'(extra), 64'd0);
      run_op("after reset", 32'h12345678, 32'h9ABCDEF0, 6'd4, 1'b0, 1'b0,
             64'h23456789_ABCDEF00, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
